// File: rtl/spi_dac_scanner.sv
// spi_dac_scanner: scans enabled DAC channels and shifts one 24-bit SPI frame per channel.
// Ports: clk/reset (sync, active-high), dac_data/ch_en/simul_update in, SPI pins + frame_done/scan_done/busy out.
module spi_dac_scanner #(
  parameter int NCH      = 4,
  parameter int DAC_BITS = 12,
  parameter int CLK_DIV  = 2,
  parameter int CS_GAP   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NCH*DAC_BITS-1:0] dac_data,
  input  logic [NCH-1:0]          ch_en,
  input  logic                    simul_update,
  output logic                    spi_sck,
  output logic                    spi_sdo,
  output logic                    spi_dac_cs,
  output logic                    frame_done,
  output logic                    scan_done,
  output logic                    busy
);

  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam int FW    = 24;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LATCH,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t                  state_q, state_d;
  logic [NCH*DAC_BITS-1:0] data_q, data_d;
  logic [NCH-1:0]          mask_q, mask_d;
  logic                    simul_q, simul_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic                    last_q, last_d;
  logic [FW-1:0]           frame_q, frame_d;
  logic [4:0]              bit_q, bit_d;
  logic [PH_W-1:0]         ph_q, ph_d;
  logic                    half_q, half_d;
  logic [GAP_W-1:0]        gap_q, gap_d;

  logic sck_q, sck_d;
  logic sdo_q, sdo_d;
  logic cs_q, cs_d;
  logic fdone_q, fdone_d;
  logic sdone_q, sdone_d;
  logic busy_q, busy_d;

  // Channel search: lowest live channel in LATCH,
  // next higher shadow channel in GAP.
  logic [NCH-1:0]          src;
  logic [NCH*DAC_BITS-1:0] src_data;
  logic                    src_simul;
  int                      start;
  logic                    hit;
  logic [CH_W-1:0]         hit_ch;
  logic                    hit_last;
  logic [DAC_BITS-1:0]     sample;
  logic [3:0]              cmd;
  logic [15:0]             field;
  logic [FW-1:0]           new_frame;
  logic                    load;

  always_comb begin
    src       = ch_en;
    src_data  = dac_data;
    src_simul = simul_update;
    start     = 0;
    if (state_q == S_GAP) begin
      src       = mask_q;
      src_data  = data_q;
      src_simul = simul_q;
      start     = int'(ch_q) + 1;
    end
    hit    = 1'b0;
    hit_ch = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (src[i] && (i >= start)) begin
        hit    = 1'b1;
        hit_ch = CH_W'(i);
      end
    end
    hit_last = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (src[i] && (i > int'(hit_ch))) hit_last = 1'b0;
    end
    sample = src_data[int'(hit_ch)*DAC_BITS +: DAC_BITS];
    if (!src_simul) cmd = 4'b0011;
    else if (hit_last) cmd = 4'b0010;
    else cmd = 4'b0000;
    field     = 16'(sample) << (16 - DAC_BITS);
    new_frame = {cmd, 4'(hit_ch), field};
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mask_d  = mask_q;
    simul_d = simul_q;
    ch_d    = ch_q;
    last_d  = last_q;
    frame_d = frame_q;
    bit_d   = bit_q;
    ph_d    = ph_q;
    half_d  = half_q;
    gap_d   = gap_q;
    fdone_d = 1'b0;
    sdone_d = 1'b0;
    load    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (|ch_en) state_d = S_LATCH;
      end
      S_LATCH: begin
        if (hit) begin
          data_d  = dac_data;
          mask_d  = ch_en;
          simul_d = simul_update;
          load    = 1'b1;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (ph_q == PH_W'(CLK_DIV - 1)) begin
          ph_d   = '0;
          half_d = ~half_q;
          if (half_q) begin
            frame_d = {frame_q[FW-2:0], 1'b0};
            if (bit_q == 5'd23) begin
              bit_d   = '0;
              gap_d   = '0;
              fdone_d = 1'b1;
              sdone_d = last_q;
              state_d = S_GAP;
            end else begin
              bit_d = bit_q + 5'd1;
            end
          end
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GAP_W'(CS_GAP - 1)) begin
          if (hit) begin
            load    = 1'b1;
            state_d = S_SHIFT;
          end else if (|ch_en) begin
            state_d = S_LATCH;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      ch_d    = hit_ch;
      last_d  = hit_last;
      frame_d = new_frame;
      bit_d   = '0;
      ph_d    = '0;
      half_d  = 1'b0;
    end

    // Pins follow the next state so they line up with state_q.
    cs_d   = (state_d != S_SHIFT);
    sck_d  = (state_d == S_SHIFT) && half_d;
    sdo_d  = (state_d == S_SHIFT) && frame_d[FW-1];
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      mask_q  <= '0;
      simul_q <= 1'b0;
      ch_q    <= '0;
      last_q  <= 1'b0;
      frame_q <= '0;
      bit_q   <= '0;
      ph_q    <= '0;
      half_q  <= 1'b0;
      gap_q   <= '0;
      sck_q   <= 1'b0;
      sdo_q   <= 1'b0;
      cs_q    <= 1'b1;
      fdone_q <= 1'b0;
      sdone_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      simul_q <= simul_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
      frame_q <= frame_d;
      bit_q   <= bit_d;
      ph_q    <= ph_d;
      half_q  <= half_d;
      gap_q   <= gap_d;
      sck_q   <= sck_d;
      sdo_q   <= sdo_d;
      cs_q    <= cs_d;
      fdone_q <= fdone_d;
      sdone_q <= sdone_d;
      busy_q  <= busy_d;
    end
  end

  assign spi_sck    = sck_q;
  assign spi_sdo    = sdo_q;
  assign spi_dac_cs = cs_q;
  assign frame_done = fdone_q;
  assign scan_done  = sdone_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_spi_dac_scanner.sv
// tb_spi_dac_scanner: decodes the SPI pins into frames and
// compares them with frames derived from the channel inputs.
module tb_spi_dac_scanner;
  localparam int NCH = 4;
  localparam int DB  = 12;
  localparam int CD  = 2;
  localparam int CG  = 2;
  localparam int FRM = 48*CD + CG;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NCH*DB-1:0] dac_data = '0;
  logic [NCH-1:0]    ch_en = '0;
  logic              simul_update = 1'b0;
  logic spi_sck, spi_sdo, spi_dac_cs;
  logic frame_done, scan_done, busy;

  int nerr = 0;
  int nchk = 0;

  spi_dac_scanner #(
    .NCH(NCH), .DAC_BITS(DB), .CLK_DIV(CD), .CS_GAP(CG)
  ) dut (
    .clk(clk), .reset(reset), .dac_data(dac_data),
    .ch_en(ch_en), .simul_update(simul_update),
    .spi_sck(spi_sck), .spi_sdo(spi_sdo),
    .spi_dac_cs(spi_dac_cs), .frame_done(frame_done),
    .scan_done(scan_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  logic [23:0] sh = '0;
  int          nb = 0, lowlen = 0;
  int          sck_rises = 0, cs_low_cnt = 0, busy_cnt = 0;
  int          fd_cnt = 0, sd_cnt = 0;
  logic        prev_cs = 1'b1, prev_sck = 1'b0;
  logic [23:0] got_q[$];
  int          len_q[$];
  int          bits_q[$];
  logic        fd_q[$];
  int          sd_cyc[$];
  logic [23:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus monitor; all its state clears while reset is high.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      sh = '0; nb = 0; lowlen = 0;
      sck_rises = 0; cs_low_cnt = 0; busy_cnt = 0;
      fd_cnt = 0; sd_cnt = 0;
      got_q.delete(); len_q.delete(); bits_q.delete();
      fd_q.delete(); sd_cyc.delete();
    end else begin
      if (spi_sck && !prev_sck) begin
        sh = {sh[22:0], spi_sdo};
        nb++;
        sck_rises++;
      end
      if (!spi_dac_cs) begin
        lowlen++;
        cs_low_cnt++;
      end
      if (busy) busy_cnt++;
      if (spi_dac_cs && !prev_cs) begin
        got_q.push_back(sh);
        len_q.push_back(lowlen);
        bits_q.push_back(nb);
        fd_q.push_back(frame_done);
        sh = '0; nb = 0; lowlen = 0;
      end
      if (frame_done) fd_cnt++;
      if (scan_done) begin
        sd_cnt++;
        sd_cyc.push_back(cyc);
      end
    end
    prev_cs  = spi_dac_cs;
    prev_sck = spi_sck;
  end

  // Expected frames of one scan, lowest channel first.
  task automatic add_exp(input logic [47:0] d, input logic [3:0] m,
                         input logic s);
    int hi;
    int cmd;
    int smp;
    logic [47:0] tmp;
    hi = -1;
    for (int i = 0; i < NCH; i++) if (m[i]) hi = i;
    for (int c = 0; c < NCH; c++) begin
      if (m[c]) begin
        if (!s) cmd = 3;
        else if (c == hi) cmd = 2;
        else cmd = 0;
        tmp = d >> (c*DB);
        smp = int'(tmp[DB-1:0]);
        exp_q.push_back(24'((cmd << 20) | (c << 16) | (smp << (16-DB))));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frames(input int n, input string tag);
    int b;
    b = 0;
    while (got_q.size() < n && b < n*FRM*2 + 200) begin
      tick();
      b++;
    end
    chk({tag, " timeout"}, 32'(got_q.size() >= n), 32'd1);
  endtask

  task automatic run_case(input string tag,
                          input logic [47:0] d1, input logic [3:0] m1,
                          input logic s1,
                          input logic [47:0] d2, input logic [3:0] m2,
                          input logic s2, input int chg_at);
    int k1, k2, n;
    exp_q.delete();
    add_exp(d1, m1, s1);
    k1 = exp_q.size();
    add_exp(d2, m2, s2);
    k2 = exp_q.size() - k1;
    n  = k1 + k2;
    tick();
    reset = 1'b1;
    dac_data = d1; ch_en = m1; simul_update = s1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (chg_at) tick();
    dac_data = d2; ch_en = m2; simul_update = s2;
    wait_frames(n, tag);
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      chk($sformatf("%s frame%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      chk($sformatf("%s cslen%0d", tag, i), len_q[i], 48*CD);
      chk($sformatf("%s bits%0d", tag, i), bits_q[i], 24);
      chk($sformatf("%s fdone%0d", tag, i), 32'(fd_q[i]), 32'd1);
    end
    chk({tag, " fdone_cnt"}, fd_cnt, n);
    chk({tag, " sdone_cnt"}, sd_cnt, 2);
    if (sd_cyc.size() >= 2)
      chk({tag, " period"}, sd_cyc[1] - sd_cyc[0], 1 + k2*FRM);
  endtask

  localparam logic [47:0] DT = 48'hFFF_456_123_ABC;

  initial begin
    logic [47:0] rd1, rd2;
    logic [3:0]  rm1, rm2;
    logic        rs1, rs2;
    int          b;

    // Idle with nothing enabled, then a single channel.
    reset = 1'b1;
    dac_data = DT; ch_en = 4'h0; simul_update = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst cs", 32'(spi_dac_cs), 32'd1);
    chk("rst sck", 32'(spi_sck), 32'd0);
    chk("rst sdo", 32'(spi_sdo), 32'd0);
    chk("rst fdone", 32'(frame_done), 32'd0);
    chk("rst sdone", 32'(scan_done), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    tick();
    reset = 1'b0;
    repeat (1000) tick();
    chk("idle sck", sck_rises, 0);
    chk("idle cs", cs_low_cnt, 0);
    chk("idle busy", busy_cnt, 0);
    ch_en = 4'h8;
    wait_frames(1, "single");
    if (got_q.size() >= 1)
      chk("single frame", 32'(got_q[0]), 32'h23FFF0);

    run_case("t1", DT, 4'hF, 1'b1, DT, 4'hF, 1'b1, 3);
    run_case("t2", DT, 4'hF, 1'b0, DT, 4'hF, 1'b0, 3);
    run_case("t3", DT, 4'h5, 1'b1, DT, 4'h5, 1'b1, 3);
    run_case("t4", DT, 4'hF, 1'b1, {DT[47:12], 12'h000}, 4'hF, 1'b1, 50);

    // Reset in the middle of a frame.
    tick();
    reset = 1'b1;
    dac_data = DT; ch_en = 4'hF; simul_update = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    b = 0;
    while (nb < 10 && b < 2000) begin
      tick();
      b++;
    end
    chk("midrst timeout", 32'(nb >= 10), 32'd1);
    @(negedge clk);
    chk("midrst cs low", 32'(spi_dac_cs), 32'd0);
    tick();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst cs", 32'(spi_dac_cs), 32'd1);
    chk("midrst sck", 32'(spi_sck), 32'd0);
    chk("midrst sdo", 32'(spi_sdo), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    tick();
    reset = 1'b0;
    wait_frames(1, "midrst");
    if (got_q.size() >= 1)
      chk("midrst frame", 32'(got_q[0]), 32'h00ABC0);

    // Random inputs, changed at a random point of the first scan.
    for (int it = 0; it < 6; it++) begin
      rd1 = {16'($urandom), $urandom};
      rd2 = {16'($urandom), $urandom};
      rm1 = 4'($urandom_range(1, 15));
      rm2 = 4'($urandom_range(1, 15));
      rs1 = 1'($urandom_range(0, 1));
      rs2 = 1'($urandom_range(0, 1));
      run_case($sformatf("rnd%0d", it), rd1, rm1, rs1, rd2, rm2, rs2,
               int'($urandom_range(3, $countones(rm1)*FRM - 3)));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
